// File: rtl/fibo_gen.sv
// fibo_gen: Fibonacci term generator with valid/ready output and overflow tracking
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      begin a sequence (accepted only in IDLE), latching seed0, seed1 and count
//   out_data   current term, out_idx its 0-based index, out_valid/out_ready handshake
//   busy       not IDLE; done is a one-cycle end pulse; ovf is sticky overflow of this sequence
module fibo_gen #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 8,
  parameter int MODE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  input  logic [IDX_W-1:0] count,
  output logic [WIDTH-1:0] out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             ovf
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] fa, fb;
  logic fb_bad;
  logic [IDX_W-1:0] idx, cnt;
  logic [WIDTH:0] sum;
  logic hs, last, stop;
  assign sum = {1'b0, fa} + {1'b0, fb};
  assign hs = (state == RUN) && out_ready;
  assign last = idx == cnt - 1'b1;
  // fb_bad marks the term about to be emitted; in stop mode it ends the run instead
  assign stop = last || (MODE == 1 && fb_bad);
  assign out_data = fa;
  assign out_idx = idx;
  assign out_valid = state == RUN;
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_comb begin
    state_nx = state == IDLE ? (start ? (count == '0 ? DONE : RUN) : IDLE) :
               state == RUN  ? (hs && stop ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      fa <= '0;
      fb <= '0;
      fb_bad <= 1'b0;
      idx <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) begin
        ovf <= 1'b0;
        cnt <= count;
        // an empty sequence leaves the visible term and index untouched
        if (count != '0) begin
          fa <= seed0;
          fb <= seed1;
          fb_bad <= 1'b0;
          idx <= '0;
        end
      end else if (hs) begin
        ovf <= ovf | fb_bad;
        if (!stop) begin
          fa <= fb;
          fb <= sum[WIDTH-1:0];
          fb_bad <= sum[WIDTH] | fb_bad;
          idx <= idx + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_fibo_gen.sv
// tb_fibo_gen: scoreboard bench for fibo_gen in wrap and stop overflow modes
module tb_fibo_gen;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b1;
  logic st[3];
  logic [15:0] s16a = '0, s16b = '0;
  logic [7:0] s8a = '0, s8b = '0, cnt = '0;
  logic [15:0] d0;
  logic [7:0] d1, d2;
  logic [15:0] od[3];
  logic [7:0] oi[3];
  logic ov[3], bz[3], dn[3], of[3];
  int errors = 0, checks = 0;
  int qd[3][$], qi[3][$], qo[3][$];

  always #5 clk = ~clk;
  assign od[0] = d0;
  assign od[1] = {8'h00, d1};
  assign od[2] = {8'h00, d2};

  fibo_gen #(.WIDTH(16), .IDX_W(8), .MODE(0)) u0 (
    .clk(clk), .rst(rst), .start(st[0]), .seed0(s16a), .seed1(s16b), .count(cnt),
    .out_data(d0), .out_idx(oi[0]), .out_valid(ov[0]), .out_ready(rdy),
    .busy(bz[0]), .done(dn[0]), .ovf(of[0]));
  fibo_gen #(.WIDTH(8), .IDX_W(8), .MODE(1)) u1 (
    .clk(clk), .rst(rst), .start(st[1]), .seed0(s8a), .seed1(s8b), .count(cnt),
    .out_data(d1), .out_idx(oi[1]), .out_valid(ov[1]), .out_ready(rdy),
    .busy(bz[1]), .done(dn[1]), .ovf(of[1]));
  fibo_gen #(.WIDTH(8), .IDX_W(8), .MODE(0)) u2 (
    .clk(clk), .rst(rst), .start(st[2]), .seed0(s8a), .seed1(s8b), .count(cnt),
    .out_data(d2), .out_idx(oi[2]), .out_valid(ov[2]), .out_ready(rdy),
    .busy(bz[2]), .done(dn[2]), .ovf(of[2]));

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // exact-integer reference: a term is bad once its true value no longer fits in w bits
  task automatic model(input int k, input longint s0, input longint s1, input int c,
                       input int w, input bit mode, output int n, output bit fo);
    longint x, y, t, lim;
    x = s0;
    y = s1;
    lim = longint'(1) << w;
    fo = 1'b0;
    n = 0;
    for (int i = 0; i < c; i++) begin
      if (x >= lim) begin
        fo = 1'b1;
        if (mode) break;
      end
      qd[k].push_back(int'(x % lim));
      qi[k].push_back(i);
      qo[k].push_back(int'(fo));
      n++;
      t = x + y;
      x = y;
      y = t;
    end
    if (n == c && x >= lim) fo = 1'b1;
  endtask

  always @(negedge clk)
    if (rst)
      for (int k = 0; k < 3; k++)
        if (ov[k] && rdy) begin
          if (qd[k].size() == 0) chk($sformatf("u%0d_extra_term", k), int'(oi[k]), -1);
          else begin
            chk($sformatf("u%0d_data", k), int'(od[k]), qd[k].pop_front());
            chk($sformatf("u%0d_idx", k), int'(oi[k]), qi[k].pop_front());
            chk($sformatf("u%0d_ovf", k), int'(of[k]), qo[k].pop_front());
          end
        end

  task automatic run(input int k, input int s0, input int s1, input int c, input bit rr,
                     input int hold, input int hidx, input bit poke);
    int n, nt, hc;
    bit fo;
    n = 0;
    hc = 0;
    model(k, longint'(s0), longint'(s1), c, k == 0 ? 16 : 8, k == 1, nt, fo);
    if (k == 0) begin
      s16a = s0[15:0];
      s16b = s1[15:0];
    end else begin
      s8a = s0[7:0];
      s8b = s1[7:0];
    end
    cnt = c[7:0];
    st[k] = 1'b1;
    @(posedge clk); #1;
    st[k] = 1'b0;
    forever begin
      @(negedge clk);
      n++;
      chk($sformatf("u%0d_busy", k), int'(bz[k]), 1);
      if (dn[k] || n > 200) break;
      @(posedge clk); #1;
      st[k] = poke && n == 3;
      if (poke && n == 3) begin
        s16a = 16'd999;
        s8a = 8'd99;
      end
      if (rr) rdy = 1'($urandom_range(0, 1));
      if (hold >= 0 && hc == 0 && ov[k] && int'(od[k]) == hold) begin
        rdy = 1'b0;
        hc = 1;
        repeat (3) begin
          @(negedge clk);
          n++;
          chk("held_data", int'(od[k]), hold);
          chk("held_idx", int'(oi[k]), hidx);
          chk("held_valid", int'(ov[k]), 1);
          @(posedge clk); #1;
          st[k] = 1'b0;
        end
        rdy = 1'b1;
      end
    end
    st[k] = 1'b0;
    chk($sformatf("u%0d_timeout", k), int'(n > 200), 0);
    if (!rr) chk($sformatf("u%0d_cycles", k), n, nt + 1 + 3 * hc);
    chk($sformatf("u%0d_done_valid", k), int'(ov[k]), 0);
    chk($sformatf("u%0d_final_ovf", k), int'(of[k]), int'(fo));
    @(negedge clk);
    chk($sformatf("u%0d_done_pulse", k), int'(dn[k]), 0);
    chk($sformatf("u%0d_idle_busy", k), int'(bz[k]), 0);
    chk($sformatf("u%0d_queue_left", k), qd[k].size(), 0);
    qd[k].delete();
    qi[k].delete();
    qo[k].delete();
    @(posedge clk); #1;
    rdy = 1'b1;
  endtask

  initial begin
    int nt, g;
    bit fo;
    st[0] = 1'b0;
    st[1] = 1'b0;
    st[2] = 1'b0;
    #12;
    chk("rst_valid", int'(ov[0]), 0);
    chk("rst_busy", int'(bz[0]), 0);
    chk("rst_done", int'(dn[0]), 0);
    chk("rst_ovf", int'(of[0]), 0);
    chk("rst_data", int'(od[0]), 0);
    chk("rst_idx", int'(oi[0]), 0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("idle_no_start", int'(bz[0]), 0);
    run(0, 0, 1, 10, 1'b0, -1, 0, 1'b0);
    chk("a_last_data", int'(od[0]), 34);
    chk("a_last_idx", int'(oi[0]), 9);
    run(0, 0, 1, 10, 1'b0, 5, 5, 1'b1);
    run(0, 0, 1, 0, 1'b0, -1, 0, 1'b0);
    chk("c0_keep_data", int'(od[0]), 34);
    chk("c0_keep_idx", int'(oi[0]), 9);
    run(1, 0, 1, 20, 1'b0, -1, 0, 1'b0);
    chk("stop_data", int'(od[1]), 233);
    chk("stop_idx", int'(oi[1]), 13);
    run(2, 0, 1, 20, 1'b0, -1, 0, 1'b0);
    chk("wrap_data", int'(od[2]), 85);
    chk("wrap_idx", int'(oi[2]), 19);
    run(2, 1, 2, 5, 1'b0, -1, 0, 1'b0);
    for (int r = 0; r < 6; r++)
      run(0, int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)),
          int'($urandom_range(1, 12)), 1'b1, -1, 0, 1'b0);
    for (int r = 0; r < 4; r++)
      run(1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
          int'($urandom_range(1, 12)), 1'b1, -1, 0, 1'b0);
    model(0, 40000, 40000, 10, 16, 1'b0, nt, fo);
    s16a = 16'd40000;
    s16b = 16'd40000;
    cnt = 8'd10;
    st[0] = 1'b1;
    @(posedge clk); #1;
    st[0] = 1'b0;
    g = 0;
    while (oi[0] != 8'd4 && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    chk("reach_idx4", int'(oi[0]), 4);
    chk("pre_rst_ovf", int'(of[0]), 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", int'(ov[0]), 0);
    chk("arst_data", int'(od[0]), 0);
    chk("arst_idx", int'(oi[0]), 0);
    chk("arst_busy", int'(bz[0]), 0);
    chk("arst_ovf", int'(of[0]), 0);
    qd[0].delete();
    qi[0].delete();
    qo[0].delete();
    repeat (2) begin
      @(negedge clk);
      chk("arst_no_done", int'(dn[0]), 0);
    end
    rst = 1'b1;
    #1;
    chk("release_busy", int'(bz[0]), 0);
    chk("release_data", int'(od[0]), 0);
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_busy", int'(bz[0]), 0);
      chk("post_rst_done", int'(dn[0]), 0);
      chk("post_rst_valid", int'(ov[0]), 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
